// File: rtl/ps2_tx_interface.sv
// Host-to-device PS/2 command transmitter with CPU-bus command/status access.
// Optional device-clock watchdog: define PS2_TX_TIMEOUT_EN.
module ps2_tx_interface #(
  parameter int unsigned INHIBIT_CYCLES = 1500,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic        clock,
  input  logic        n_reset,
  input  logic        read,
  input  logic        write,
  input  logic        command_cs,
  input  logic        status_cs,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_out_valid,
  input  logic        ps2_clock_in,
  input  logic        ps2_data_in,
  output logic        ps2_clock_oe,
  output logic        ps2_data_oe,
  output logic        rx_inhibit
);

  localparam int unsigned INH_W = 11;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    INHIBIT      = 3'd1,
    START        = 3'd2,
    DATA         = 3'd3,
    PARITY       = 3'd4,
    STOP         = 3'd5,
    ACK          = 3'd6,
    WAIT_RELEASE = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         clk_sync_q, clk_sync_d;
  logic [1:0]         data_sync_q, data_sync_d;
  logic               clk_prev_q, clk_prev_d;
  logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               parity_q, parity_d;
  logic               busy_q, busy_d;
  logic               error_q, error_d;
  logic               overrun_q, overrun_d;
  logic               clock_oe_q, clock_oe_d;
  logic               data_oe_q, data_oe_d;

  logic clk_s, data_s, fall;
  logic cmd_wr, ovr_set, status_rd, err_set;
  logic unused_ok;

  assign unused_ok = ^{data_in[31:8], TIMEOUT_CYCLES == 32'd0};

  // Two-flop synchronisers and the previous synced clock sample for fall detection
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clock_in};
    data_sync_d = {data_sync_q[0], ps2_data_in};
    clk_prev_d  = clk_sync_q[1];
  end

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fall   = clk_prev_q & ~clk_s;

  assign cmd_wr    = write && command_cs && !busy_q;
  assign ovr_set   = write && command_cs && busy_q;
  assign status_rd = read && status_cs;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WDOG_W = 18;

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              wdog_active, timeout;

  always_comb begin
    wdog_active = (state_q == START) || (state_q == DATA) || (state_q == PARITY) ||
                  (state_q == STOP) || (state_q == ACK);
    timeout     = wdog_active && (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
  end

  // Restarts on every device clock fall and on any state change; saturates
  always_comb begin
    wdog_d = wdog_q;
    if (!wdog_active || fall || (state_d != state_q)) begin
      wdog_d = '0;
    end else if (wdog_q != '1) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) wdog_q <= '0;
    else          wdog_q <= wdog_d;
  end
`endif

  // Frame sequencer; line changes land one cycle after a detected fall
  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = '0;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    busy_d     = busy_q;
    clock_oe_d = clock_oe_q;
    data_oe_d  = data_oe_q;
    err_set    = 1'b0;
    case (state_q)
      IDLE: begin
        clock_oe_d = 1'b0;
        data_oe_d  = 1'b0;
        if (cmd_wr) begin
          shift_d    = data_in[7:0];
          parity_d   = ~^data_in[7:0];
          busy_d     = 1'b1;
          clock_oe_d = 1'b1;
          state_d    = INHIBIT;
        end
      end
      INHIBIT: begin
        clock_oe_d = 1'b1;
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          data_oe_d = 1'b1;
          state_d   = START;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      START: begin
        clock_oe_d = 1'b0;
        data_oe_d  = 1'b1;
        bit_idx_d  = '0;
        state_d    = DATA;
      end
      DATA: begin
        if (fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == IDX_W'(7)) state_d = PARITY;
          else                        bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      PARITY: begin
        if (fall) begin
          data_oe_d = ~parity_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          data_oe_d = 1'b0;
          state_d   = ACK;
        end
      end
      ACK: begin
        if (fall) begin
          err_set = data_s;
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (clk_s && data_s) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        clock_oe_d = 1'b0;
        data_oe_d  = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    if (timeout) begin
      clock_oe_d = 1'b0;
      data_oe_d  = 1'b0;
      busy_d     = 1'b0;
      err_set    = 1'b1;
      state_d    = IDLE;
    end
`endif
  end

  // Sticky status; a set in the same cycle as a clearing read wins
  always_comb begin
    error_d   = err_set | (error_q & ~status_rd);
    overrun_d = ovr_set | (overrun_q & ~status_rd);
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      inh_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      overrun_q   <= 1'b0;
      clock_oe_q  <= 1'b0;
      data_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      inh_cnt_q   <= inh_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
      overrun_q   <= overrun_d;
      clock_oe_q  <= clock_oe_d;
      data_oe_q   <= data_oe_d;
    end
  end

  assign data_out       = {29'b0, overrun_q, error_q, busy_q};
  assign data_out_valid = status_rd;
  assign ps2_clock_oe   = clock_oe_q;
  assign ps2_data_oe    = data_oe_q;
  assign rx_inhibit     = busy_q;

endmodule

// File: tb/tb_ps2_tx_interface.sv
// Bench for ps2_tx_interface: open-drain PS/2 device model plus wire-bit and status scoreboards.
`timescale 1ns/1ps
module tb_ps2_tx_interface;

  localparam int INH  = 1500;
  localparam int TMO  = 3000;
  localparam int HALF = 40;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic        command_cs = 1'b0;
  logic        status_cs = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic        ps2_clock_oe, ps2_data_oe, rx_inhibit;
  logic        dev_clk_low = 1'b0;
  logic        dev_data_low = 1'b0;
  logic        ps2_clk_line, ps2_data_line;

  int n_checks = 0;
  int n_pass = 0;
  logic        exp_bit_q[$];
  logic [31:0] exp_st_q[$];

  assign ps2_clk_line  = ~(ps2_clock_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_tx_interface #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock         (clk),
    .n_reset       (n_reset),
    .read          (read),
    .write         (write),
    .command_cs    (command_cs),
    .status_cs     (status_cs),
    .data_in       (data_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .ps2_clock_in  (ps2_clk_line),
    .ps2_data_in   (ps2_data_line),
    .ps2_clock_oe  (ps2_clock_oe),
    .ps2_data_oe   (ps2_data_oe),
    .rx_inhibit    (rx_inhibit)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected wire levels at device rising edges: start, d0..d7, odd parity, stop
  function automatic void push_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    exp_bit_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_bit_q.push_back(b[i]);
      if (b[i]) ones++;
    end
    exp_bit_q.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
    exp_bit_q.push_back(1'b1);
  endfunction

  task automatic cpu_write(input logic [7:0] b, input bit expect_tx);
    @(negedge clk);
    write = 1'b1; command_cs = 1'b1; data_in = {24'hA5A5A5, b};
    if (expect_tx) push_frame(b);
    @(negedge clk);
    write = 1'b0; command_cs = 1'b0; data_in = '0;
  endtask

  task automatic status_read(input string tag, input logic [31:0] exp);
    logic [31:0] want;
    exp_st_q.push_back(exp);
    @(negedge clk);
    read = 1'b1; status_cs = 1'b1;
    #1;
    check({tag, "_valid"}, 32'(data_out_valid), 32'd1);
    want = exp_st_q.pop_front();
    check(tag, data_out, want);
    @(negedge clk);
    read = 1'b0; status_cs = 1'b0;
  endtask

  task automatic sample_bit();
    logic want;
    want = (exp_bit_q.size() > 0) ? exp_bit_q.pop_front() : 1'bx;
    check("wire_bit", 32'(ps2_data_line), 32'(want));
  endtask

  // Device: waits out host inhibit, then clocks n_rise rising edges (11 = full frame + ack clock)
  task automatic dev_frame(input int n_rise, input bit do_ack);
    int cnt;
    cnt = 0;
    while (ps2_clk_line && cnt < 100) begin @(negedge clk); cnt++; end
    check("inhibit_start", 32'(ps2_clk_line), 32'd0);
    cnt = 0;
    while (!ps2_clk_line && cnt < 4000) begin @(negedge clk); cnt++; end
    check("inhibit_len", 32'(cnt >= INH && cnt <= INH + 3), 32'd1);
    sample_bit();
    for (int k = 1; k < n_rise; k++) begin
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      sample_bit();
    end
    if (n_rise == 11) begin
      repeat (HALF / 2) @(negedge clk);
      dev_data_low = do_ack;
      check("host_released_data", 32'(ps2_data_oe), 32'd0);
      repeat (HALF / 2) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF / 2) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while (rx_inhibit && cnt < 1000) begin @(negedge clk); cnt++; end
    check("busy_release", 32'(rx_inhibit), 32'd0);
  endtask

  task automatic full_frame(input logic [7:0] b, input bit do_ack);
    cpu_write(b, 1'b1);
    check("busy_after_write", 32'(rx_inhibit), 32'd1);
    dev_frame(11, do_ack);
    wait_idle();
    check("frame_drained", 32'(exp_bit_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] t2 [2];
    t2[0] = 8'h01;
    t2[1] = 8'hFF;

    repeat (3) @(negedge clk);
    check("rst_clock_oe", 32'(ps2_clock_oe), 32'd0);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("rst_status", data_out, 32'd0);
    check("rst_rx_inhibit", 32'(rx_inhibit), 32'd0);
    check("rst_valid", 32'(data_out_valid), 32'd0);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);

    // Set-LEDs command, acknowledged
    full_frame(8'hED, 1'b1);
    status_read("st_ed", 32'h0);

    // Parity 0 and parity 1 bytes
    foreach (t2[i]) begin
      full_frame(t2[i], 1'b1);
      status_read("st_parity", 32'h0);
    end

    // Device does not acknowledge
    full_frame(8'hF4, 1'b0);
    status_read("st_nak", 32'h2);
    status_read("st_nak_clr", 32'h0);

    // Overrun: second write while the first frame is mid-flight
    cpu_write(8'hAA, 1'b1);
    fork
      dev_frame(11, 1'b1);
      begin
        repeat (1800) @(negedge clk);
        cpu_write(8'h55, 1'b0);
        status_read("st_ovr", 32'h5);
      end
    join
    wait_idle();
    check("ovr_drained", 32'(exp_bit_q.size()), 32'd0);
    status_read("st_ovr_done", 32'h0);

    // Silent device
    cpu_write(8'hFF, 1'b0);
`ifdef PS2_TX_TIMEOUT_EN
    repeat (INH + TMO - 100) @(negedge clk);
    check("tmo_not_early", 32'(rx_inhibit), 32'd1);
    repeat (300) @(negedge clk);
    check("tmo_clock_oe", 32'(ps2_clock_oe), 32'd0);
    check("tmo_data_oe", 32'(ps2_data_oe), 32'd0);
    status_read("st_tmo", 32'h2);
    status_read("st_tmo_clr", 32'h0);
`else
    repeat (INH + 2 * TMO) @(negedge clk);
    check("hang_data_oe", 32'(ps2_data_oe), 32'd1);
    status_read("st_hang", 32'h1);
    n_reset = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);
`endif

    // Reset during bit 4, then a clean frame
    cpu_write(8'hED, 1'b1);
    dev_frame(5, 1'b0);
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (10) @(negedge clk);
    check("bit4_driven", 32'(ps2_data_oe), 32'd1);
    n_reset = 1'b0;
    #1;
    check("abort_clock_oe", 32'(ps2_clock_oe), 32'd0);
    check("abort_data_oe", 32'(ps2_data_oe), 32'd0);
    check("abort_busy", 32'(rx_inhibit), 32'd0);
    check("abort_status", data_out, 32'd0);
    dev_clk_low = 1'b0;
    exp_bit_q.delete();
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);
    full_frame(8'hED, 1'b1);
    status_read("st_after_abort", 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
